// File: rtl/seq_divider.sv
// Multicycle restoring divider: one quotient bit per cycle, signed or unsigned per request.
// Quotient is returned on lo and remainder on hi; Div0 flags a zero divisor without starting a run.
module seq_divider #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             Div0
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] dvd_q, dvd_d;   // dividend magnitude, shifted out as quotient bits shift in
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;

  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] diff;
  logic             nonneg;

  assign rem_sh = {rem_q, dvd_q[WIDTH-1]};
  assign diff   = {1'b0, rem_sh} - {2'b00, dvs_q};
  // A non-negative trial always fits in WIDTH bits because the remainder stays below the divisor.
  assign nonneg = (diff[WIDTH+1:WIDTH] == 2'b00);

  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    a_neg_d = a_neg_q;
    b_neg_d = b_neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    div0_d  = div0_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          a_neg_d = signed_op & A[WIDTH-1];
          b_neg_d = signed_op & B[WIDTH-1];
          div0_d  = (B == '0);
          if (B == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = RUN;
            busy_d  = 1'b1;
            dvd_d   = a_neg_d ? -A : A;
            dvs_d   = b_neg_d ? -B : B;
            rem_d   = '0;
            cnt_d   = '0;
          end
        end
      end
      RUN: begin
        if (nonneg) rem_d = diff[WIDTH-1:0];
        else        rem_d = rem_sh[WIDTH-1:0];
        dvd_d = {dvd_q[WIDTH-2:0], nonneg};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) state_d = FIX;
      end
      FIX: begin
        lo_d    = (a_neg_q ^ b_neg_q) ? -dvd_q : dvd_q;
        hi_d    = a_neg_q ? -rem_q : rem_q;
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      a_neg_q <= 1'b0;
      b_neg_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      a_neg_q <= a_neg_d;
      b_neg_q <= b_neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
  assign Div0 = div0_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider at WIDTH=32 with hand-computed quotients and remainders.
module tb_seq_divider;

  localparam int W = 32;

  logic         clock, reset, start, signed_op;
  logic [W-1:0] A, B, hi, lo;
  logic         busy, done, Div0;

  int n_cmp = 0;
  int n_err = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clock(clock), .reset(reset), .start(start), .signed_op(signed_op),
    .A(A), .B(B), .busy(busy), .done(done), .hi(hi), .lo(lo), .Div0(Div0)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the accepting edge.
  task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    A = a; B = b; signed_op = s; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    A = $urandom; B = $urandom; signed_op = $urandom_range(0, 1);
  endtask

  // Counts edges after the accepting edge until done is seen; 999 if it never comes.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    if (!done) lat = 999;
  endtask

  task automatic run_div(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [W-1:0] exp_lo, input logic [W-1:0] exp_hi);
    int lat;
    launch(a, b, s);
    wait_done(lat);
    check({tag, " latency"}, lat, 33);
    check({tag, " lo"}, lo, exp_lo);
    check({tag, " hi"}, hi, exp_hi);
    check({tag, " Div0"}, Div0, 0);
    check({tag, " busy in done cycle"}, busy, 0);
  endtask

  initial begin
    int lat;
    int pulses;
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; A = '0; B = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset Div0", Div0, 0);

    launch(32'd100, 32'd7, 1'b0);
    check("100/7 busy after accept", busy, 1);
    wait_done(lat);
    check("100/7 latency", lat, 33);
    check("100/7 lo", lo, 14);
    check("100/7 hi", hi, 2);
    check("100/7 Div0", Div0, 0);
    check("100/7 busy in done cycle", busy, 0);
    @(posedge clock); #1;
    check("100/7 done single cycle", done, 0);
    check("100/7 lo held", lo, 14);

    run_div("-7/2", 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_div("7/-2", 32'd7, 32'hFFFF_FFFE, 1'b1, 32'hFFFF_FFFD, 32'd1);
    run_div("MIN/-1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'd0);
    run_div("MAXU/1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'd0);
    run_div("100/MAXU", 32'd100, 32'hFFFF_FFFF, 1'b0, 32'd0, 32'd100);
    run_div("-8/2", 32'hFFFF_FFF8, 32'd2, 1'b1, 32'hFFFF_FFFC, 32'd0);
    run_div("MIN/3 unsigned", 32'h8000_0000, 32'd3, 1'b0, 32'h2AAA_AAAA, 32'd2);
    run_div("100/7 again", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2);

    launch(32'd55, 32'd0, 1'b1);
    wait_done(lat);
    check("div0 latency", lat, 0);
    check("div0 flag", Div0, 1);
    check("div0 busy", busy, 0);
    check("div0 hi retained", hi, 2);
    check("div0 lo retained", lo, 14);
    @(posedge clock); #1;
    check("div0 done single cycle", done, 0);
    check("div0 flag sticky", Div0, 1);
    launch(32'd9, 32'd3, 1'b0);
    check("div0 clears on accept", Div0, 0);
    wait_done(lat);
    check("9/3 latency", lat, 33);
    check("9/3 lo", lo, 3);
    check("9/3 hi", hi, 0);

    launch(32'd1000, 32'd10, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    A = 32'd5; B = 32'd5; signed_op = 1'b0; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    lat = 0;
    while (!done && lat < 100) begin
      @(posedge clock); #1;
      lat++;
    end
    check("ignored start latency", lat, 28);
    check("ignored start lo", lo, 100);
    check("ignored start hi", hi, 0);

    @(posedge clock); #1;
    launch(32'd1000, 32'd10, 1'b0);
    wait_done(lat);
    check("b2b first lo", lo, 100);
    launch(32'd20, 32'd6, 1'b0);
    check("b2b done dropped", done, 0);
    check("b2b busy", busy, 1);
    wait_done(lat);
    check("b2b second latency", lat, 33);
    check("b2b second lo", lo, 3);
    check("b2b second hi", hi, 2);

    launch(32'd1000, 32'd10, 1'b0);
    repeat (9) @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("async reset busy", busy, 0);
    check("async reset hi", hi, 0);
    check("async reset lo", lo, 0);
    check("async reset Div0", Div0, 0);
    @(posedge clock); #1;
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(posedge clock); #1;
      if (done) pulses++;
    end
    check("no done after abort", pulses, 0);
    run_div("20/6 after reset", 32'd20, 32'd6, 1'b0, 32'd3, 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
